// File: rtl/monkey_motion_pkg.sv
// Shared types and constants for the monkey sprite motion controller.
//   motion_state_t : GROUND / AIR / CLIMB encoding, also driven on motionState
//   EDGE_*         : bit positions inside HitEdgeCode and the latched hit vector
package monkey_motion_pkg;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    AIR    = 2'd1,
    CLIMB  = 2'd2
  } motion_state_t;

  localparam int unsigned EDGE_BOTTOM = 0;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_LEFT   = 3;

  localparam int unsigned EDGE_W = 4;

endpackage

// File: rtl/frame_hit_latch.sv
// Per-frame sticky accumulator for collision edges and rope contact.
// Collision edges and rope contact are short pulses that can arrive anywhere in
// a frame; they are remembered until the next frame strobe, where the motion
// logic consumes them.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset, drops any pending hits at once
//   sof_i        : frame strobe; sticky state is cleared on this cycle
//   hit_valid_i  : this cycle's collision counts (already qualified by caller)
//   hit_edge_i   : edge code of this cycle's collision
//   on_rope_i    : sprite overlaps a rope this cycle
//   hits_o       : sticky | current edge hits (meaningful on the sof_i cycle)
//   rope_o       : sticky | current rope contact
module frame_hit_latch
  import monkey_motion_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sof_i,
  input  logic              hit_valid_i,
  input  logic [EDGE_W-1:0] hit_edge_i,
  input  logic              on_rope_i,
  output logic [EDGE_W-1:0] hits_o,
  output logic              rope_o
);

  logic [EDGE_W-1:0] hits_q, hits_d;
  logic              rope_q, rope_d;
  logic [EDGE_W-1:0] hits_cur;

  assign hits_cur = hit_valid_i ? hit_edge_i : '0;

  // The evaluated value includes this cycle so a hit arriving together with the
  // frame strobe is not lost.
  assign hits_o = hits_q | hits_cur;
  assign rope_o = rope_q | on_rope_i;

  always_comb begin
    hits_d = hits_o;
    rope_d = rope_o;
    if (sof_i) begin
      hits_d = '0;
      rope_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hits_q <= '0;
      rope_q <= 1'b0;
    end else begin
      hits_q <= hits_d;
      rope_q <= rope_d;
    end
  end

endmodule

// File: rtl/monkey_motion_fsm.sv
// Player-sprite motion controller. Collision/rope contacts gathered during a
// frame are resolved once per startOfFrame by a GROUND/AIR/CLIMB machine that
// sets the speeds; positions are fixed-point integrators clamped to the screen.
//   clk, resetN      : clock, asynchronous active-low reset
//   startOfFrame     : one-cycle frame strobe; all state advances only here
//   left/right/up/downPressed : key levels
//   collision, num_hit, HitEdgeCode : collision pulse, score-digit qualifier, edge
//   onRope           : sprite overlaps a rope
//   topLeftX/Y       : sprite position in whole pixels (signed, floor)
//   motionState      : 0 GROUND, 1 AIR, 2 CLIMB
//   facingLeft       : last nonzero horizontal motion was to the left
module monkey_motion_fsm
  import monkey_motion_pkg::*;
#(
  parameter int INITIAL_X      = 280,
  parameter int INITIAL_Y      = 185,
  parameter int FP_SHIFT       = 6,
  parameter int WALK_SPEED     = 200,
  parameter int JUMP_SPEED     = 300,
  parameter int CLIMB_SPEED    = 100,
  parameter int GRAVITY        = 10,
  parameter int MAX_FALL_SPEED = 230,
  parameter int X_MIN          = -9,
  parameter int X_MAX          = 570,
  parameter int Y_FLOOR        = 400
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               leftPressed,
  input  logic               rightPressed,
  input  logic               upPressed,
  input  logic               downPressed,
  input  logic               collision,
  input  logic               num_hit,
  input  logic               onRope,
  input  logic [3:0]         HitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         motionState,
  output logic               facingLeft
);

  localparam int FpOne    = 2 ** FP_SHIFT;
  localparam int XInitFp  = INITIAL_X * FpOne;
  localparam int YInitFp  = INITIAL_Y * FpOne;
  localparam int XMinFp   = X_MIN * FpOne;
  localparam int XMaxFp   = X_MAX * FpOne;
  localparam int YFloorFp = Y_FLOOR * FpOne;

  // ---------------------------------------------------------------------------
  // Frame hit accumulation
  // ---------------------------------------------------------------------------
  logic [EDGE_W-1:0] hits;
  logic              rope;

  frame_hit_latch u_hit_latch (
    .clk_i       (clk),
    .rst_ni      (resetN),
    .sof_i       (startOfFrame),
    .hit_valid_i (collision & ~num_hit),
    .hit_edge_i  (HitEdgeCode),
    .on_rope_i   (onRope),
    .hits_o      (hits),
    .rope_o      (rope)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  motion_state_t      state_q, state_d;
  logic signed [31:0] pos_x_q, pos_x_d;
  logic signed [31:0] pos_y_q, pos_y_d;
  logic signed [31:0] xspd_q, xspd_d;
  logic signed [31:0] yspd_q, yspd_d;
  logic               facing_q, facing_d;
  logic               up_prev_q, up_prev_d;

  // ---------------------------------------------------------------------------
  // Evaluated flags
  // ---------------------------------------------------------------------------
  logic ledge, head, wall_r, wall_l, jump_req;

  // Standing on the floor line counts as a ledge so the sprite rests there
  // instead of bouncing between AIR and the floor clamp.
  assign ledge    = hits[EDGE_BOTTOM] | (pos_y_q >= YFloorFp);
  assign head     = hits[EDGE_TOP];
  assign wall_r   = hits[EDGE_RIGHT];
  assign wall_l   = hits[EDGE_LEFT];
  assign jump_req = upPressed & ~up_prev_q;

  // ---------------------------------------------------------------------------
  // State machine and vertical speed
  // ---------------------------------------------------------------------------
  motion_state_t      state_fsm;
  logic signed [31:0] yspd_fsm;
  logic signed [31:0] yspd_grav;

  assign yspd_grav = yspd_q + GRAVITY;

  always_comb begin
    state_fsm = state_q;
    yspd_fsm  = yspd_q;
    unique case (state_q)
      GROUND: begin
        if (rope && (upPressed || downPressed)) begin
          state_fsm = CLIMB;
          yspd_fsm  = '0;
        end else if (jump_req) begin
          state_fsm = AIR;
          yspd_fsm  = -JUMP_SPEED;
        end else if (!ledge) begin
          state_fsm = AIR;
          yspd_fsm  = '0;
        end else begin
          yspd_fsm = '0;
        end
      end
      AIR: begin
        if (rope && upPressed) begin
          state_fsm = CLIMB;
          yspd_fsm  = '0;
        end else if (ledge && (yspd_q >= 0)) begin
          state_fsm = GROUND;
          yspd_fsm  = '0;
        end else if (head && (yspd_q < 0)) begin
          yspd_fsm = '0;
        end else if (yspd_grav > MAX_FALL_SPEED) begin
          yspd_fsm = MAX_FALL_SPEED;
        end else begin
          yspd_fsm = yspd_grav;
        end
      end
      CLIMB: begin
        if (!rope || leftPressed || rightPressed) begin
          state_fsm = AIR;
          yspd_fsm  = '0;
        end else if (upPressed && !downPressed) begin
          yspd_fsm = -CLIMB_SPEED;
        end else if (downPressed && !upPressed) begin
          yspd_fsm = CLIMB_SPEED;
        end else begin
          yspd_fsm = '0;
        end
      end
      default: begin
        state_fsm = AIR;
        yspd_fsm  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Position integration and clamps (uses the speeds from the previous frame)
  // ---------------------------------------------------------------------------
  logic signed [31:0] x_sum, y_sum, x_clamped;
  logic               floor_hit;

  assign x_sum     = pos_x_q + xspd_q;
  assign y_sum     = pos_y_q + yspd_q;
  assign floor_hit = (y_sum > YFloorFp);

  always_comb begin
    x_clamped = x_sum;
    if (x_sum < XMinFp) begin
      x_clamped = XMinFp;
    end else if (x_sum > XMaxFp) begin
      x_clamped = XMaxFp;
    end
  end

  // ---------------------------------------------------------------------------
  // Horizontal speed
  // ---------------------------------------------------------------------------
  motion_state_t      state_next;
  logic signed [31:0] xspd_walk, xspd_next;

  assign state_next = floor_hit ? GROUND : state_fsm;

  always_comb begin
    xspd_walk = '0;
    if (rightPressed && !leftPressed && !wall_r) begin
      xspd_walk = WALK_SPEED;
    end else if (leftPressed && !rightPressed && !wall_l) begin
      xspd_walk = -WALK_SPEED;
    end
  end

  assign xspd_next = (state_next == CLIMB) ? '0 : xspd_walk;

  // ---------------------------------------------------------------------------
  // Next-state: everything holds except on the frame strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    xspd_d    = xspd_q;
    yspd_d    = yspd_q;
    facing_d  = facing_q;
    up_prev_d = up_prev_q;
    if (startOfFrame) begin
      up_prev_d = upPressed;
      pos_x_d   = x_clamped;
      xspd_d    = xspd_next;
      if (xspd_next != 0) begin
        facing_d = (xspd_next < 0);
      end
      // The floor clamp overrides whatever the state machine decided.
      if (floor_hit) begin
        pos_y_d = YFloorFp;
        yspd_d  = '0;
        state_d = GROUND;
      end else begin
        pos_y_d = y_sum;
        yspd_d  = yspd_fsm;
        state_d = state_fsm;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= AIR;
      pos_x_q   <= XInitFp;
      pos_y_q   <= YInitFp;
      xspd_q    <= '0;
      yspd_q    <= '0;
      facing_q  <= 1'b0;
      up_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      xspd_q    <= xspd_d;
      yspd_q    <= yspd_d;
      facing_q  <= facing_d;
      up_prev_q <= up_prev_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: arithmetic shift floors toward minus infinity
  // ---------------------------------------------------------------------------
  assign topLeftX    = 11'(pos_x_q >>> FP_SHIFT);
  assign topLeftY    = 11'(pos_y_q >>> FP_SHIFT);
  assign motionState = state_q;
  assign facingLeft  = facing_q;

endmodule
